// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_pkg;

    // MDU scoreboard states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } mdu_state_t;

    // ALU operand mux select encodings
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Width of the MDU down-counter; holds MDU_LAT-1 for MDU_LAT up to 15
    localparam int MDU_CW = 4;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Per-operand forwarding priority select (EX/MEM over MEM/WB over register file).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the current stage registers.
// Ports: i_src operand register; i_exmem_* / i_memwb_* producer stage
//        write enable and destination; o_sel operand mux select.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_exmem_regwrite,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_memwb_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    output logic [1:0]        o_sel
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    // Register 0 is hard-wired zero, so a write to it never produces a value
    assign w_hit_exmem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
    assign w_hit_memwb = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

    // EX/MEM holds the younger result, so it wins when both match
    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_exmem) begin
            o_sel = FWD_EXMEM;
        end else if (w_hit_memwb) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: EX operand forwarding, load-use stall, single-entry MDU scoreboard, stall counter.
// Latency: forwarding/stall combinational; MDU write-back strobe MDU_LAT+1 cycles after an accepted start.
// Backpressure: stall holds PC/IF-ID and bubbles ID/EX; an mdu_start seen together with stall is not accepted.
// Ports: clk/reset (async active-high); ifid_*, idex_*, exmem_*, memwb_* pipeline register fields;
//        mdu_start/mdu_rd MDU issue from ID; perf_clr counter clear; forward_a/b operand selects;
//        stall; mdu_busy, mdu_wb_valid, mdu_wb_rd scoreboard status; id_bypass_a/b ID bypass selects;
//        stall_cycles saturating counter.
// Build option: HAZARD_MDU_BYPASS_EN enables the ID-stage bypass of the MDU result during write-back.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,   // legal range 2..15
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              mdu_start,
    input  logic [REG_AW-1:0] mdu_rd,
    input  logic              perf_clr,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              mdu_busy,
    output logic              mdu_wb_valid,
    output logic [REG_AW-1:0] mdu_wb_rd,
    output logic              id_bypass_a,
    output logic              id_bypass_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    mdu_state_t        r_state;
    logic [MDU_CW-1:0] r_cnt;
    logic [REG_AW-1:0] r_rd;
    logic              r_busy;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_load_use;
    logic       w_rd_hit_a;
    logic       w_rd_hit_b;
    logic       w_raw;
    logic       w_struct;
    logic       w_stall;
    logic       w_accept;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src            (idex_rs),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (w_fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src            (idex_rt),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (w_fwd_b)
    );

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_load_use = idex_memread && (idex_rd != '0) &&
                        ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

    // Pending MDU destination read by the instruction in ID; r0 never blocks
    assign w_rd_hit_a = (r_rd != '0) && (r_rd == ifid_rs);
    assign w_rd_hit_b = (r_rd != '0) && (r_rd == ifid_rt);

`ifdef HAZARD_MDU_BYPASS_EN
    // In WB the result is steered straight into ID, so only RUN blocks readers
    assign w_raw       = (r_state == RUN) && (w_rd_hit_a || w_rd_hit_b);
    assign id_bypass_a = (r_state == WB) && w_rd_hit_a && !reset;
    assign id_bypass_b = (r_state == WB) && w_rd_hit_b && !reset;
`else
    // Readers wait until the register file write in WB has completed
    assign w_raw       = ((r_state == RUN) || (r_state == WB)) && (w_rd_hit_a || w_rd_hit_b);
    assign id_bypass_a = 1'b0;
    assign id_bypass_b = 1'b0;
`endif

    // Only one MDU operation can be in flight
    assign w_struct = mdu_start && (r_state == RUN);
    assign w_stall  = w_load_use || w_raw || w_struct;

    // A stalled start is re-presented by ID next cycle, so it is simply ignored now
    assign w_accept = mdu_start && !w_stall && (r_state != RUN);

    // Combinational outputs are forced quiet while reset is held
    assign forward_a = reset ? FWD_RF : w_fwd_a;
    assign forward_b = reset ? FWD_RF : w_fwd_b;
    assign stall     = w_stall && !reset;

    // ------------------------------------------------------------------
    // MDU scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_busy     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_cnt   <= MDU_CW'(MDU_LAT - 1);
                        r_rd    <= mdu_rd;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Counter runs MDU_LAT-1 .. 0, giving exactly MDU_LAT RUN cycles
                    if (r_cnt == '0) begin
                        r_state    <= WB;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WB: begin
                    r_wb_valid <= 1'b0;
                    r_wb_rd    <= '0;
                    if (w_accept) begin
                        r_state <= RUN;
                        r_cnt   <= MDU_CW'(MDU_LAT - 1);
                        r_rd    <= mdu_rd;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_wb_valid <= 1'b0;
                    r_wb_rd    <= '0;
                end
            endcase
        end
    end

    assign mdu_busy     = r_busy;
    assign mdu_wb_valid = r_wb_valid;
    assign mdu_wb_rd    = r_wb_rd;

    // ------------------------------------------------------------------
    // Stall performance counter (clear wins over increment, saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized scoreboard bench for hazard_fwd_ctrl against a cycle-indexed reference model.
// Latency: expectations are queued per cycle and popped by a monitor on the falling edge.
// Backpressure: n/a; the bench drives every cycle.
module tb_hazard_fwd_ctrl;

    localparam int AW   = 5;
    localparam int LAT  = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd;
    logic          idex_memread, exmem_regwrite, memwb_regwrite;
    logic [AW-1:0] exmem_rd, memwb_rd, mdu_rd;
    logic          mdu_start, perf_clr;
    logic [1:0]    forward_a, forward_b;
    logic          stall, mdu_busy, mdu_wb_valid, id_bypass_a, id_bypass_b;
    logic [AW-1:0] mdu_wb_rd;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .idex_rs        (idex_rs),
        .idex_rt        (idex_rt),
        .idex_memread   (idex_memread),
        .idex_rd        (idex_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .mdu_start      (mdu_start),
        .mdu_rd         (mdu_rd),
        .perf_clr       (perf_clr),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .stall          (stall),
        .mdu_busy       (mdu_busy),
        .mdu_wb_valid   (mdu_wb_valid),
        .mdu_wb_rd      (mdu_wb_rd),
        .id_bypass_a    (id_bypass_a),
        .id_bypass_b    (id_bypass_b),
        .stall_cycles   (stall_cycles)
    );

    typedef struct {
        int fa, fb, st, busy, wbv, bpa, bpb, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   wb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: one pending MDU op described by its issue-relative write-back cycle
    bit m_act   = 1'b0;
    int m_rd    = 0;
    int m_wb_t  = 0;
    int m_cnt   = 0;
    int t       = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d: got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    function automatic int fwd_ref(input int src);
        if (exmem_regwrite && exmem_rd != 0 && int'(exmem_rd) == src) return 1;
        if (memwb_regwrite && memwb_rd != 0 && int'(memwb_rd) == src) return 2;
        return 0;
    endfunction

    function automatic logic [AW-1:0] rreg();
        return AW'($urandom_range(0, 7));
    endfunction

    // mode: 0 random, 1 held load-use stall, 3 held stall with perf_clr, 4 reset
    task automatic cycle(input int mode);
        exp_t e;
        bit   in_run, in_wb, lu, hit_a, hit_b, raw, sh, st;
        @(posedge clk);
        #1;
        ifid_rs        = rreg();
        ifid_rt        = rreg();
        idex_rs        = rreg();
        idex_rt        = rreg();
        idex_rd        = rreg();
        exmem_rd       = rreg();
        memwb_rd       = rreg();
        mdu_rd         = rreg();
        idex_memread   = ($urandom_range(0, 3) == 0);
        exmem_regwrite = $urandom_range(0, 1) == 1;
        memwb_regwrite = $urandom_range(0, 1) == 1;
        mdu_start      = ($urandom_range(0, 9) < 3);
        perf_clr       = ($urandom_range(0, 99) < 3);
        reset          = (mode == 4) || (mode == 0 && $urandom_range(0, 99) == 0);
        if (mode == 1 || mode == 3) begin
            idex_memread = 1'b1;
            idex_rd      = 5'd9;
            ifid_rt      = 5'd9;
            mdu_start    = 1'b0;
            perf_clr     = (mode == 3);
        end

        in_run = m_act && (t < m_wb_t);
        in_wb  = m_act && (t == m_wb_t);

        if (reset) begin
            e = '{0, 0, 0, 0, 0, 0, 0, 0};
            m_act = 1'b0;
            m_rd  = 0;
            m_cnt = 0;
        end else begin
            lu    = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
            hit_a = m_rd != 0 && m_rd == int'(ifid_rs);
            hit_b = m_rd != 0 && m_rd == int'(ifid_rt);
`ifdef HAZARD_MDU_BYPASS_EN
            raw   = in_run && (hit_a || hit_b);
            e.bpa = (in_wb && hit_a) ? 1 : 0;
            e.bpb = (in_wb && hit_b) ? 1 : 0;
`else
            raw   = (in_run || in_wb) && (hit_a || hit_b);
            e.bpa = 0;
            e.bpb = 0;
`endif
            sh     = mdu_start && in_run;
            st     = lu || raw || sh;
            e.fa   = fwd_ref(int'(idex_rs));
            e.fb   = fwd_ref(int'(idex_rt));
            e.st   = st ? 1 : 0;
            e.busy = (in_run || in_wb) ? 1 : 0;
            e.wbv  = in_wb ? 1 : 0;
            e.cnt  = m_cnt;
            if (in_wb) wb_q.push_back(m_rd);

            if (perf_clr) m_cnt = 0;
            else if (st && m_cnt < CMAX) m_cnt++;
            if (in_wb) m_act = 1'b0;
            if (mdu_start && !st) begin
                m_act  = 1'b1;
                m_rd   = int'(mdu_rd);
                m_wb_t = t + LAT + 1;
            end
        end
        exp_q.push_back(e);
        t++;
    endtask

    // Monitor: compare every presented cycle; write-back payloads come from their own queue
    initial begin
        exp_t e;
        int   rd_exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("forward_a", int'(forward_a), e.fa);
                chk("forward_b", int'(forward_b), e.fb);
                chk("stall", int'(stall), e.st);
                chk("mdu_busy", int'(mdu_busy), e.busy);
                chk("mdu_wb_valid", int'(mdu_wb_valid), e.wbv);
                chk("id_bypass_a", int'(id_bypass_a), e.bpa);
                chk("id_bypass_b", int'(id_bypass_b), e.bpb);
                chk("stall_cycles", int'(stall_cycles), e.cnt);
                if (e.wbv != 0 && wb_q.size() > 0) begin
                    rd_exp = wb_q.pop_front();
                    if (mdu_wb_valid) chk("mdu_wb_rd", int'(mdu_wb_rd), rd_exp);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        ifid_rs        = '0;
        ifid_rt        = '0;
        idex_rs        = '0;
        idex_rt        = '0;
        idex_rd        = '0;
        idex_memread   = 1'b0;
        exmem_regwrite = 1'b0;
        exmem_rd       = '0;
        memwb_regwrite = 1'b0;
        memwb_rd       = '0;
        mdu_start      = 1'b0;
        mdu_rd         = '0;
        perf_clr       = 1'b0;

        repeat (2) cycle(4);
        repeat (1500) cycle(0);
        repeat (CMAX + 10) cycle(1);
        cycle(3);
        repeat (3) cycle(1);
        repeat (1500) cycle(0);
        repeat (2) cycle(4);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("wb_queue_drained", wb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
